// File: rtl/mul1024_seq.sv
// mul1024_seq: word-serial sequencer in front of a wide parallel multiplier.
//
// Operand words are streamed in, LS word of operand 1 first, then operand 2. The
// multiplier is then released from reset for MUL_LATENCY cycles, its product is
// captured, and the product is streamed back out LS word first.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_abort      synchronous return to LOAD (highest priority after reset)
//   i_wr_valid   input word valid
//   i_wr_data    input operand word
//   o_wr_ready   input word accepted (LOAD state)
//   o_rd_valid   result word valid (DRAIN state)
//   o_rd_data    result word
//   i_rd_ready   consumer accepts result word
//   o_busy       high in any state other than LOAD
//   o_done       one-cycle pulse after the last result word is accepted
//   o_mul_in1    multiplier operand 1
//   o_mul_in2    multiplier operand 2
//   o_mul_rstn   multiplier active-low reset / enable
//   i_mul_out    multiplier product
module mul1024_seq #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OP_W        = 1024,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_abort,
    input  logic                i_wr_valid,
    input  logic [DATA_W-1:0]   i_wr_data,
    output logic                o_wr_ready,
    output logic                o_rd_valid,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_rd_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic [OP_W-1:0]     o_mul_in1,
    output logic [OP_W-1:0]     o_mul_in2,
    output logic                o_mul_rstn,
    input  logic [2*OP_W-1:0]   i_mul_out
);

    localparam int unsigned NW    = OP_W / DATA_W;
    localparam int unsigned NRES  = 2 * NW;
    localparam int unsigned CNT_W = (NRES > 1) ? $clog2(NRES) : 1;
    localparam int unsigned LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_rcnt;
    logic [LAT_W-1:0]  r_lat;
    logic [OP_W-1:0]   r_in1;
    logic [OP_W-1:0]   r_in2;
    logic [2*OP_W-1:0] r_res;
    logic              r_done;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_wr_last;
    logic              w_rd_last;
    logic              w_lat_end;
    logic              w_is_in1;
    logic [CNT_W-1:0]  w_wsel;

    assign o_wr_ready = (r_state == ST_LOAD);
    assign o_rd_valid = (r_state == ST_DRAIN);
    assign o_busy     = (r_state != ST_LOAD);
    assign o_mul_rstn = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done     = r_done;
    assign o_mul_in1  = r_in1;
    assign o_mul_in2  = r_in2;

    assign w_wr_fire = i_wr_valid & o_wr_ready;
    assign w_rd_fire = o_rd_valid & i_rd_ready;
    assign w_wr_last = (r_wcnt == CNT_W'(NRES - 1));
    assign w_rd_last = (r_rcnt == CNT_W'(NRES - 1));
    assign w_lat_end = (r_lat == LAT_W'(MUL_LATENCY - 1));

    // Word index within the selected operand.
    assign w_is_in1 = (r_wcnt < CNT_W'(NW));
    assign w_wsel   = w_is_in1 ? r_wcnt : (r_wcnt - CNT_W'(NW));

    // Zero outside DRAIN so no stale or partial result is ever presented.
    always_comb begin
        o_rd_data = '0;
        if (r_state == ST_DRAIN) begin
            o_rd_data = r_res[32'(r_rcnt) * DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_LOAD;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_lat   <= '0;
            r_in1   <= '0;
            r_in2   <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                // Any coincident handshake is dropped; operand registers keep their contents.
                r_state <= ST_LOAD;
                r_wcnt  <= '0;
                r_rcnt  <= '0;
                r_lat   <= '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_wr_fire) begin
                            if (w_is_in1) begin
                                r_in1[32'(w_wsel) * DATA_W +: DATA_W] <= i_wr_data;
                            end else begin
                                r_in2[32'(w_wsel) * DATA_W +: DATA_W] <= i_wr_data;
                            end
                            if (w_wr_last) begin
                                r_wcnt  <= '0;
                                r_state <= ST_RUN;
                            end else begin
                                r_wcnt <= r_wcnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        // r_lat == k during RUN cycle k+1; capture on the edge closing
                        // the MUL_LATENCY-th cycle.
                        if (w_lat_end) begin
                            r_lat   <= '0;
                            r_res   <= i_mul_out;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_lat <= r_lat + LAT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (w_rd_fire) begin
                            if (w_rd_last) begin
                                r_rcnt  <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_LOAD;
                            end else begin
                                r_rcnt <= r_rcnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mul1024_seq.md
Name: mul1024_seq

Overview:
- Word-serial sequencer in front of the 1024x1024 parallel multiplier datapath.
- Accepts both operands as a stream of 32-bit words and drives them onto the multiplier's wide operand buses.
- Releases the multiplier from reset, waits its fixed latency and captures the 2048-bit product.
- Streams the product back as 32-bit words, so a narrow bus master can run full multiplies without 129 memory-mapped registers.

Parameters:
DATA_W, 32, stream word width in bits
OP_W, 1024, operand width in bits; must be a multiple of DATA_W
MUL_LATENCY, 4, cycles from mul_rstn high with stable operands to a valid mul_out; must be >= 1

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
abort  in  1  synchronous clear back to LOAD; highest priority after rstn
wr_valid  in  1  input word valid
wr_data  in  DATA_W  operand word
wr_ready  out  1  sequencer accepts input word
rd_valid  out  1  result word valid
rd_data  out  DATA_W  result word
rd_ready  in  1  consumer accepts result word
busy  out  1  high in any state other than LOAD
done  out  1  one-cycle pulse after the last result word is accepted
mul_in1  out  OP_W  multiplier operand 1
mul_in2  out  OP_W  multiplier operand 2
mul_rstn  out  1  multiplier active-low reset/enable
mul_out  in  2*OP_W  multiplier product

Behaviour:
- Reset (rstn low, asynchronous) applies these values; all registers, counters and mul_in1/mul_in2 cleared:
  - state = LOAD, wr_ready = 1, rd_valid = 0, rd_data = 0.
  - busy = 0, done = 0, mul_rstn = 0, mul_in1 = mul_in2 = 0.
- Word counts: NW = OP_W/DATA_W (32). Result words = 2*NW (64).
- LOAD:
  - wr_ready = 1; mul_rstn = 0.
  - On wr_valid & wr_ready, word index w (0..2*NW-1) is written, LS word first.
  - w < NW writes mul_in1[w*DATA_W +: DATA_W]; otherwise writes mul_in2[(w-NW)*DATA_W +: DATA_W].
  - Words not yet rewritten keep their previous value.
  - Acceptance of word 2*NW-1 moves to RUN on the next edge, with w cleared.
  - Gaps in wr_valid are legal; the counter holds.
- RUN:
  - wr_ready = 0, mul_rstn = 1, operands held stable.
  - A latency counter counts MUL_LATENCY cycles starting at the first RUN cycle.
  - At the edge closing RUN cycle MUL_LATENCY, mul_out is captured into a 2*OP_W result register; state moves to DRAIN.
- DRAIN:
  - mul_rstn = 1, rd_valid = 1, rd_data = result word r (LS word first), r from 0 to 2*NW-1.
  - r advances on rd_valid & rd_ready. rd_data is stable while rd_ready is low.
  - Acceptance of word 2*NW-1 moves to LOAD: done = 1 for exactly that next cycle, mul_rstn = 0, r cleared.
- Latency, with continuous handshakes: the last input word is accepted at cycle 0 and rd_valid first rises at cycle MUL_LATENCY+1.
- abort:
  - Effective on the edge where it is sampled high: state = LOAD, all counters = 0, mul_rstn = 0, rd_valid = 0, no done.
  - A handshake coincident with abort is discarded: neither the written word nor the read word counts as transferred.
  - Operand registers are not cleared.
- rstn asserted mid-operation: immediate return to reset values; no partial result is ever presented.
- done is never asserted for aborted operations.
- Back-to-back operations: a new load may begin the cycle after done. Every operation rewrites all operand words.

Test Plan:
- Reset, then load In1 = 1 and In2 = 1 (word 0 = 1, all other words 0) with continuous valid, rd_ready = 1 -> rd_valid rises exactly MUL_LATENCY+1 cycles after the last write; word 0 = 0x00000001, words 1..63 = 0; done pulses once.
- In1 = In2 = all ones -> words 0 = 0x00000001, 1..31 = 0, 32 = 0xFFFFFFFE, 33..63 = 0xFFFFFFFF.
- In1 = 2^1023, In2 = 2 -> word 32 = 0x00000001, all others 0. Apply random wr_valid gaps and rd_ready deasserted 50% of cycles -> rd_data holds while stalled; exactly 64 words; one done.
- abort after 20 writes, then a full fresh load of 3 x 5 -> result word 0 = 0x0000000F; no done for the aborted run. Repeat with abort in RUN and mid-DRAIN -> state LOAD, mul_rstn = 0 the next cycle.
- abort coincident with wr_valid & wr_ready on word 63 -> no transition to RUN; wr_ready = 1, busy = 0.
- rstn pulsed low mid-DRAIN at word 10 -> all outputs at reset values immediately (asynchronously); a subsequent 1x1 run yields correct results.
